// File: rtl/decode_execute_pkg.sv
// decode_execute_pkg: opcode encoding and hex glyph table shared by the decode/execute unit
package decode_execute_pkg;
  typedef enum logic [2:0] {
    OP_SUB = 3'd0,
    OP_ADD = 3'd1,
    OP_OR  = 3'd2,
    OP_AND = 3'd3,
    OP_SRA = 3'd4,
    OP_ROL = 3'd5,
    OP_LT  = 3'd6,
    OP_EQ  = 3'd7
  } op_e;
  // active-low {a,b,c,d,e,f,g}, lowercase b and d
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'ha: return 7'b0001000;
      4'hb: return 7'b1100000;
      4'hc: return 7'b0110001;
      4'hd: return 7'b1000010;
      4'he: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction
endpackage

// File: rtl/seq_decode_execute_seg_scan.sv
// seg_scan: time-multiplexes up to four hex digits onto an active-low 7-segment display
module seg_scan
  import decode_execute_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  output logic [3:0]  anode,
  output logic [6:0]  cathode
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(REFRESH_DIV - 1)) begin
      cnt <= '0;
      idx <= (idx == 2'(DIGITS - 1)) ? 2'd0 : idx + 2'd1;
    end else
      cnt <= cnt + 1'b1;
  assign anode = ~(4'b0001 << idx);
  assign cathode = hex_to_seg(value[{idx, 2'b00} +: 4]);
endmodule

// File: rtl/seq_decode_execute.sv
// seq_decode_execute: register file plus one-cycle ALU with write-back and hex display of the last result
module seq_decode_execute
  import decode_execute_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREG = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld_valid,
  input  logic [$clog2(NREG)-1:0] ld_addr,
  input  logic [WIDTH-1:0]        ld_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              sel,
  input  logic [$clog2(NREG)-1:0] rs_addr,
  input  logic [$clog2(NREG)-1:0] rt_addr,
  input  logic [$clog2(NREG)-1:0] rd_addr,
  output logic                    res_valid,
  output logic [WIDTH-1:0]        res_data,
  output logic [3:0]              anode,
  output logic [6:0]              cathode
);
  localparam int DIGITS = (WIDTH / 4 < 4) ? WIDTH / 4 : 4;
  logic [WIDTH-1:0] rf [NREG];
  logic [WIDTH-1:0] rs, rt, alu;
  logic accept;
  assign in_ready = !ld_valid;
  assign accept = in_valid && in_ready;
  assign rs = rf[rs_addr];
  assign rt = rf[rt_addr];
  always_comb begin
    alu = '0;
    case (op_e'(sel))
      OP_SUB: alu = rs - rt;
      OP_ADD: alu = rs + rt;
      OP_OR:  alu = rs | rt;
      OP_AND: alu = rs & rt;
      OP_SRA: alu = {rt[WIDTH-1], rt[WIDTH-1:1]};
      OP_ROL: alu = {rs[WIDTH-2:0], rs[WIDTH-1]};
      OP_LT:  alu = WIDTH'(rs < rt);
      OP_EQ:  alu = WIDTH'(rs == rt);
      default: alu = '0;
    endcase
  end
  // loads and write-back never collide: an accept implies no load this cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      res_data <= '0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= accept;
      if (ld_valid) rf[ld_addr] <= ld_data;
      else if (accept) begin
        rf[rd_addr] <= alu;
        res_data <= alu;
      end
    end
  seg_scan #(.DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)) u_scan (
    .clk(clk),
    .rst_n(rst_n),
    .value(16'(res_data)),
    .anode(anode),
    .cathode(cathode)
  );
endmodule
